// File: rtl/trap_arbiter_pkg.sv
// Shared constants for the trap arbiter: cause codes, exc_vec bit indices,
// the 2-bit FSM state encoding and the mstatus.MIE bit position.
package trap_arbiter_pkg;

    localparam int EXC_IAM   = 0;
    localparam int EXC_IAF   = 1;
    localparam int EXC_ILL   = 2;
    localparam int EXC_BRK   = 3;
    localparam int EXC_ECALL = 4;
    localparam int EXC_LAM   = 5;
    localparam int EXC_LAF   = 6;
    localparam int EXC_SAM   = 7;
    localparam int EXC_SAF   = 8;

    localparam logic [31:0] CAUSE_MISALIGNED_FETCH    = 32'd0;
    localparam logic [31:0] CAUSE_FETCH_ACCESS        = 32'd1;
    localparam logic [31:0] CAUSE_ILLEGAL_INSTRUCTION = 32'd2;
    localparam logic [31:0] CAUSE_BREAKPOINT          = 32'd3;
    localparam logic [31:0] CAUSE_MISALIGNED_LOAD     = 32'd4;
    localparam logic [31:0] CAUSE_LOAD_ACCESS         = 32'd5;
    localparam logic [31:0] CAUSE_MISALIGNED_STORE    = 32'd6;
    localparam logic [31:0] CAUSE_STORE_ACCESS        = 32'd7;
    localparam logic [31:0] CAUSE_USER_ECALL          = 32'd8;

    localparam int IRQ_MSI_BIT = 3;
    localparam int IRQ_MTI_BIT = 7;
    localparam int IRQ_MEI_BIT = 11;

    localparam logic [31:0] CAUSE_IRQ_M_SOFT  = 32'h8000_0003;
    localparam logic [31:0] CAUSE_IRQ_M_TIMER = 32'h8000_0007;
    localparam logic [31:0] CAUSE_IRQ_M_EXT   = 32'h8000_000B;

    localparam logic [31:0] BADADDR_USE_PC = 32'hFFFF_FFFF;

    localparam int          MSTATUS_MIE_BIT = 3;
    localparam logic [1:0]  PRIV_M          = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_SLEEP = 2'd3
    } state_e;

endpackage

// File: rtl/trap_arbiter_priority_encoder.sv
// Combinational trap selector: fixed-priority exception pick, falling back
// to the highest-priority pending interrupt.
module trap_priority_encoder
    import trap_arbiter_pkg::*;
(
    input  logic [8:0]  exc_vec,
    input  logic [31:0] pend,
    input  logic [1:0]  privilege_mode,
    input  logic [31:0] exc_tval,
    output logic        sel_valid,
    output logic [31:0] sel_cause,
    output logic [31:0] sel_badaddr
);

    logic unused_pend;
    assign unused_pend = ^{pend[31:12], pend[10:8], pend[6:4], pend[2:0]};

    always_comb begin
        sel_valid   = 1'b1;
        sel_cause   = '0;
        sel_badaddr = exc_tval;
        if (exc_vec[EXC_BRK]) begin
            sel_cause   = CAUSE_BREAKPOINT;
            sel_badaddr = BADADDR_USE_PC;
        end else if (exc_vec[EXC_IAF]) begin
            sel_cause = CAUSE_FETCH_ACCESS;
        end else if (exc_vec[EXC_ILL]) begin
            sel_cause = CAUSE_ILLEGAL_INSTRUCTION;
        end else if (exc_vec[EXC_IAM]) begin
            sel_cause = CAUSE_MISALIGNED_FETCH;
        end else if (exc_vec[EXC_ECALL]) begin
            // ECALL codes 8..11 track the privilege the call came from
            sel_cause   = CAUSE_USER_ECALL + {30'b0, privilege_mode};
            sel_badaddr = '0;
        end else if (exc_vec[EXC_SAM]) begin
            sel_cause = CAUSE_MISALIGNED_STORE;
        end else if (exc_vec[EXC_LAM]) begin
            sel_cause = CAUSE_MISALIGNED_LOAD;
        end else if (exc_vec[EXC_SAF]) begin
            sel_cause = CAUSE_STORE_ACCESS;
        end else if (exc_vec[EXC_LAF]) begin
            sel_cause = CAUSE_LOAD_ACCESS;
        end else if (pend[IRQ_MEI_BIT]) begin
            sel_cause   = CAUSE_IRQ_M_EXT;
            sel_badaddr = '0;
        end else if (pend[IRQ_MSI_BIT]) begin
            sel_cause   = CAUSE_IRQ_M_SOFT;
            sel_badaddr = '0;
        end else if (pend[IRQ_MTI_BIT]) begin
            sel_cause   = CAUSE_IRQ_M_TIMER;
            sel_badaddr = '0;
        end else begin
            sel_valid   = 1'b0;
            sel_badaddr = '0;
        end
    end

endmodule

// File: rtl/trap_arbiter.sv
// Trap arbiter/sequencer ahead of the CSR exception handler.
// Define TRAP_ARBITER_WFI_EN to build the WFI sleep state.
module trap_arbiter
    import trap_arbiter_pkg::*;
#(
    parameter logic [31:0] IRQ_MASK = 32'h0000_0888
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        insn_boundary,
    input  logic        exc_valid,
    input  logic [8:0]  exc_vec,
    input  logic [31:0] exc_tval,
    input  logic [31:0] mip,
    input  logic [31:0] mie,
    input  logic [31:0] mstatus,
    input  logic [1:0]  privilege_mode,
    input  logic        wfi,
    input  logic        redirect_done,
    output logic        exception_event,
    output logic [31:0] cause,
    output logic [31:0] badaddr,
    output logic        busy,
    output logic        wfi_sleep
);

    state_e      state_q, state_d;
    logic        exception_event_q, exception_event_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] badaddr_q, badaddr_d;
    logic        busy_q, busy_d;
    logic        wfi_sleep_q, wfi_sleep_d;

    logic [31:0] pend;
    logic        irq_en;
    logic [8:0]  exc_vec_eff;
    logic [31:0] pend_eff;
    logic        sel_valid;
    logic [31:0] sel_cause;
    logic [31:0] sel_badaddr;
    logic        unused_in;

    assign unused_in = ^{mstatus[31:4], mstatus[2:0], wfi};

    assign pend   = mip & mie & IRQ_MASK;
    assign irq_en = (privilege_mode != PRIV_M) || mstatus[MSTATUS_MIE_BIT];

    // Mask sources here so the encoder's choice is already the one to take
    assign exc_vec_eff = exc_valid ? exc_vec : '0;
    assign pend_eff    = (insn_boundary && irq_en) ? pend : '0;

    trap_priority_encoder u_prio (
        .exc_vec        (exc_vec_eff),
        .pend           (pend_eff),
        .privilege_mode (privilege_mode),
        .exc_tval       (exc_tval),
        .sel_valid      (sel_valid),
        .sel_cause      (sel_cause),
        .sel_badaddr    (sel_badaddr)
    );

    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        badaddr_d = badaddr_q;
        case (state_q)
            ST_IDLE: begin
                if (sel_valid) begin
                    state_d   = ST_ISSUE;
                    cause_d   = sel_cause;
                    badaddr_d = sel_badaddr;
                end
`ifdef TRAP_ARBITER_WFI_EN
                else if (wfi) begin
                    state_d = ST_SLEEP;
                end
`endif
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (redirect_done) state_d = ST_IDLE;
            end
`ifdef TRAP_ARBITER_WFI_EN
            // Wake on any pending interrupt, regardless of MIE
            ST_SLEEP: begin
                if (|pend) state_d = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
        exception_event_d = (state_d == ST_ISSUE);
        busy_d            = (state_d != ST_IDLE);
`ifdef TRAP_ARBITER_WFI_EN
        wfi_sleep_d = (state_d == ST_SLEEP);
`else
        wfi_sleep_d = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q           <= ST_IDLE;
            exception_event_q <= 1'b0;
            cause_q           <= '0;
            badaddr_q         <= '0;
            busy_q            <= 1'b0;
            wfi_sleep_q       <= 1'b0;
        end else begin
            state_q           <= state_d;
            exception_event_q <= exception_event_d;
            cause_q           <= cause_d;
            badaddr_q         <= badaddr_d;
            busy_q            <= busy_d;
            wfi_sleep_q       <= wfi_sleep_d;
        end
    end

    assign exception_event = exception_event_q;
    assign cause           = cause_q;
    assign badaddr         = badaddr_q;
    assign busy            = busy_q;
    assign wfi_sleep       = wfi_sleep_q;

endmodule

// File: tb/tb_trap_arbiter.sv
// Self-checking bench for trap_arbiter: directed scenarios plus random
// stimulus, compared every cycle against a transaction-level reference.
module tb_trap_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        insn_boundary;
    logic        exc_valid;
    logic [8:0]  exc_vec;
    logic [31:0] exc_tval;
    logic [31:0] mip;
    logic [31:0] mie;
    logic [31:0] mstatus;
    logic [1:0]  privilege_mode;
    logic        wfi;
    logic        redirect_done;
    logic        exception_event;
    logic [31:0] cause;
    logic [31:0] badaddr;
    logic        busy;
    logic        wfi_sleep;

    always #5 clk = ~clk;

    trap_arbiter #(.IRQ_MASK(32'h0000_0888)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .insn_boundary   (insn_boundary),
        .exc_valid       (exc_valid),
        .exc_vec         (exc_vec),
        .exc_tval        (exc_tval),
        .mip             (mip),
        .mie             (mie),
        .mstatus         (mstatus),
        .privilege_mode  (privilege_mode),
        .wfi             (wfi),
        .redirect_done   (redirect_done),
        .exception_event (exception_event),
        .cause           (cause),
        .badaddr         (badaddr),
        .busy            (busy),
        .wfi_sleep       (wfi_sleep)
    );

`ifdef TRAP_ARBITER_WFI_EN
    localparam bit WFI_BUILD = 1'b1;
`else
    localparam bit WFI_BUILD = 1'b0;
`endif

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: priority tables indexed by rank, plus a trap-age counter
    int exc_rank_bit [9] = '{3, 1, 2, 0, 4, 7, 5, 8, 6};
    int exc_code_of  [9] = '{0, 1, 2, 3, 8, 4, 5, 6, 7};
    int irq_rank_bit [3] = '{11, 3, 7};

    bit          m_open;
    bit          m_sleep;
    int          m_age;
    logic [31:0] m_cause;
    logic [31:0] m_badaddr;

    function automatic logic [31:0] ref_pend();
        return mip & mie & 32'h0000_0888;
    endfunction

    task automatic ref_pick(output bit found, output logic [31:0] c, output logic [31:0] b);
        found = 1'b0;
        c = '0;
        b = '0;
        if (exc_valid && exc_vec != 0) begin
            for (int r = 0; r < 9 && !found; r++) begin
                int bi;
                bi = exc_rank_bit[r];
                if (exc_vec[bi]) begin
                    found = 1'b1;
                    c = exc_code_of[bi];
                    if (bi == 4) c = 8 + int'(privilege_mode);
                    b = (bi == 3) ? 32'hFFFF_FFFF : (bi == 4) ? 32'h0 : exc_tval;
                end
            end
        end else if (insn_boundary && (privilege_mode != 2'b11 || mstatus[3]) && ref_pend() != 0) begin
            for (int r = 0; r < 3 && !found; r++) begin
                logic [31:0] p;
                p = ref_pend();
                if (p[irq_rank_bit[r]]) begin
                    found = 1'b1;
                    c = 32'h8000_0000 | irq_rank_bit[r];
                end
            end
        end
    endtask

    task automatic model_step();
        bit          f;
        logic [31:0] c, b;
        if (m_open) begin
            if (m_age >= 2 && redirect_done) m_open = 1'b0;
            else m_age++;
        end else if (m_sleep) begin
            if (ref_pend() != 0) m_sleep = 1'b0;
        end else begin
            ref_pick(f, c, b);
            if (f) begin
                m_open = 1'b1;
                m_age = 1;
                m_cause = c;
                m_badaddr = b;
            end else if (WFI_BUILD && wfi) begin
                m_sleep = 1'b1;
            end
        end
    endtask

    task automatic model_reset();
        m_open = 1'b0;
        m_sleep = 1'b0;
        m_age = 0;
        m_cause = '0;
        m_badaddr = '0;
    endtask

    task automatic check_outputs();
        check_eq("exception_event", 32'(exception_event), 32'(m_open && m_age == 1));
        check_eq("cause", cause, m_cause);
        check_eq("badaddr", badaddr, m_badaddr);
        check_eq("busy", 32'(busy), 32'(m_open || m_sleep));
        check_eq("wfi_sleep", 32'(wfi_sleep), 32'(m_sleep));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic clear_inputs();
        insn_boundary = 1'b0;
        exc_valid = 1'b0;
        exc_vec = '0;
        exc_tval = '0;
        mip = '0;
        mie = '0;
        mstatus = '0;
        privilege_mode = 2'b11;
        wfi = 1'b0;
        redirect_done = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        resetn = 1'b1;
    endtask

    // Raise one exception for a single cycle; returns in the ISSUE cycle
    task automatic fire_exc(input logic [8:0] v, input logic [31:0] t, input logic [1:0] pm);
        exc_valid = 1'b1;
        exc_vec = v;
        exc_tval = t;
        privilege_mode = pm;
        tick();
        exc_valid = 1'b0;
        exc_vec = '0;
    endtask

    // From the ISSUE cycle, let the trap complete (bounded)
    task automatic finish_trap();
        redirect_done = 1'b0;
        tick();
        tick();
        redirect_done = 1'b1;
        for (int i = 0; i < 8 && (m_open || busy); i++) tick();
        redirect_done = 1'b0;
        check_eq("trap_done_busy", 32'(busy), 32'h0);
    endtask

    initial begin
        clear_inputs();
        model_reset();
        resetn = 1'b0;
        @(negedge clk);
        check_outputs();
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 8; i++) tick();

        // ILL only
        fire_exc(9'h004, 32'h0000_0073, 2'b11);
        check_eq("ill_event", 32'(exception_event), 32'h1);
        check_eq("ill_cause", cause, 32'd2);
        check_eq("ill_badaddr", badaddr, 32'h73);
        finish_trap();

        // BRK + ILL, with redirect_done already high in the ISSUE cycle
        fire_exc(9'h00C, 32'h1234_5678, 2'b11);
        check_eq("brk_cause", cause, 32'd3);
        check_eq("brk_badaddr", badaddr, 32'hFFFF_FFFF);
        redirect_done = 1'b1;
        tick();
        check_eq("brk_busy_after_issue", 32'(busy), 32'h1);
        finish_trap();

        // ECALL from U and M
        fire_exc(9'h010, 32'hDEAD_BEEF, 2'b00);
        check_eq("ecall_u_cause", cause, 32'd8);
        finish_trap();
        fire_exc(9'h010, 32'hDEAD_BEEF, 2'b11);
        check_eq("ecall_m_cause", cause, 32'd11);
        check_eq("ecall_m_badaddr", badaddr, 32'h0);
        finish_trap();

        // Timer interrupt in M mode with MIE set
        mip = 32'h80; mie = 32'h80; mstatus = 32'h8; privilege_mode = 2'b11; insn_boundary = 1'b1;
        tick();
        check_eq("mti_cause", cause, 32'h8000_0007);
        mip = '0;
        finish_trap();

        // MIE clear in M mode: no trap
        mip = 32'h80; mstatus = 32'h0;
        tick();
        tick();
        check_eq("mti_masked_event", 32'(exception_event), 32'h0);
        check_eq("mti_masked_busy", 32'(busy), 32'h0);

        // MIE clear in U mode: taken
        privilege_mode = 2'b00;
        tick();
        check_eq("mti_user_cause", cause, 32'h8000_0007);
        mip = '0;
        finish_trap();

        // LAF together with MEI: exception first, interrupt afterwards
        mip = 32'h800; mie = 32'h800; mstatus = 32'h8; privilege_mode = 2'b11; insn_boundary = 1'b1;
        fire_exc(9'h040, 32'h0000_1000, 2'b11);
        check_eq("laf_cause", cause, 32'd5);
        check_eq("laf_badaddr", badaddr, 32'h1000);
        finish_trap();
        tick();
        check_eq("mei_cause", cause, 32'h8000_000B);
        mip = '0;
        finish_trap();

        // WFI
        clear_inputs();
        tick();
        wfi = 1'b1;
        tick();
        wfi = 1'b0;
        check_eq("wfi_sleep_entry", 32'(wfi_sleep), 32'(WFI_BUILD));
        tick();
        tick();
        mip = 32'h80; mie = 32'h80; mstatus = 32'h0; privilege_mode = 2'b11; insn_boundary = 1'b1;
        tick();
        check_eq("wfi_wake_sleep", 32'(wfi_sleep), 32'h0);
        tick();
        check_eq("wfi_wake_no_trap", 32'(exception_event), 32'h0);
        check_eq("wfi_wake_busy", 32'(busy), 32'h0);
        clear_inputs();
        tick();

        // Reset during WAIT
        fire_exc(9'h004, 32'h0000_00AA, 2'b11);
        tick();
        check_eq("pre_reset_busy", 32'(busy), 32'h1);
        do_reset();
        check_eq("reset_cause", cause, 32'h0);
        tick();

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            insn_boundary = 1'($urandom_range(0, 1));
            exc_valid = ($urandom_range(0, 3) == 0);
            exc_vec = ($urandom_range(0, 1) == 1) ? 9'(1 << $urandom_range(0, 8)) : 9'($urandom_range(0, 511));
            if ($urandom_range(0, 5) == 0) exc_vec = '0;
            exc_tval = $urandom;
            mip = ($urandom_range(0, 3) == 0) ? ($urandom & 32'h0000_0FFF) : 32'h0;
            mie = $urandom;
            mstatus = $urandom;
            privilege_mode = 2'($urandom_range(0, 3));
            wfi = ($urandom_range(0, 7) == 0);
            redirect_done = ($urandom_range(0, 2) == 0);
            tick();
            if ($urandom_range(0, 120) == 0) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/trap_arbiter.md
# trap_arbiter

Trap arbiter and sequencer in front of `csr_exception_handler`.
- Collects synchronous exception requests from the multicycle core and pending machine interrupts (`mip & mie`, gated by `mstatus.MIE` and privilege).
- Selects exactly one trap by fixed priority and issues it to the CSR unit as a one-cycle `exception_event` with `cause`/`badaddr`.
- Stalls the core until the trap redirect completes.
- Optionally parks the hart in a WFI sleep state until an enabled interrupt is pending.

## Interface
Parameters:
- `IRQ_MASK`, `32'h0000_0888`: interrupt bits eligible for arbitration (MSI 3, MTI 7, MEI 11).

Ports:
- `clk` input 1: clock.
- `resetn` input 1: reset, asynchronous, active-low.
- `insn_boundary` input 1: core is at an instruction boundary (fetch state); interrupts may be taken.
- `exc_valid` input 1: current instruction reports exceptions this cycle.
- `exc_vec` input 9: exception flags, one bit per source:
  - [0] IAM, [1] IAF, [2] ILL, [3] BRK, [4] ECALL
  - [5] LAM, [6] LAF, [7] SAM, [8] SAF
- `exc_tval` input 32: faulting address or instruction word for the current exception.
- `mip`, `mie`, `mstatus` input 32 each: live CSR values.
- `privilege_mode` input 2: current privilege.
- `wfi` input 1: a WFI instruction is retiring this cycle.
- `redirect_done` input 1: core has loaded `exception_next_pc`.
- `exception_event` output 1: one-cycle trap strobe to the CSR unit.
- `cause` output 32: mcause value for the issued trap.
- `badaddr` output 32: mtval source; `32'hFFFF_FFFF` tells the CSR unit to substitute the pc.
- `busy` output 1: core must stall.
- `wfi_sleep` output 1: hart is sleeping.

## Operation
- Exception priority, highest first, with the mcause code in brackets:
  - BRK(3) > IAF(1) > ILL(2) > IAM(0) > ECALL(8 + privilege_mode) > SAM(6) > LAM(4) > SAF(7) > LAF(5).
- Exception `badaddr` values:
  - ILL, IAM, IAF, LAM, LAF, SAM, SAF: `exc_tval`.
  - BRK: `32'hFFFF_FFFF`.
  - ECALL: 0.
- An interrupt is enabled when `privilege_mode != M`, or when `mstatus[3]` (MIE) is 1.
- Interrupt candidate set: `pend = mip & mie & IRQ_MASK`.
- Interrupt priority: MEI(11) > MSI(3) > MTI(7).
- Interrupt trap: `cause = {1'b1, 27'b0, code}`, `badaddr = 0`.
- FSM states:
  - IDLE:
    - if `exc_valid` and `|exc_vec`: latch the winning exception, go to ISSUE;
    - else if `insn_boundary`, interrupts enabled and `|pend`: latch the winning interrupt, go to ISSUE;
    - else if `wfi` (WFI build only): go to SLEEP.
  - ISSUE: `exception_event=1`, `busy=1`; unconditionally go to WAIT.
  - WAIT: `busy=1`; on `redirect_done` go to IDLE.
  - SLEEP: `wfi_sleep=1`, `busy=1`; on `|pend` go to IDLE. Wake ignores MIE, per the privileged spec.
- `exc_valid` with `exc_vec == 0` is ignored.
- `exc_valid` outside IDLE is ignored (protocol violation; not latched).
- Simultaneous exception and interrupt in IDLE: the exception wins; the interrupt stays pending and is re-evaluated at the next boundary.
- `cause` and `badaddr` are registers. They are loaded on the IDLE→ISSUE transition and hold until the next load.

## Timing
- Reset values (asynchronous): state IDLE, `exception_event=0`, `cause=0`, `badaddr=0`, `busy=0`, `wfi_sleep=0`.
- Request in cycle N → `exception_event=1` in cycle N+1, exactly one cycle wide. `cause`/`badaddr` are valid in that cycle.
- `busy` is high from N+1 through the cycle in which `redirect_done` is sampled high, and low one cycle later.
- `redirect_done` in the ISSUE cycle is ignored. Only WAIT samples it.
- Minimum trap turnaround is 3 cycles: ISSUE, WAIT, then IDLE.
- SLEEP wake: `|pend` sampled in cycle M → IDLE in M+1. The interrupt is taken if `insn_boundary` is high in M+1.
- Reset asserted in any state returns to IDLE immediately. Any in-flight trap is dropped without a strobe.

## Configuration
- `TRAP_ARBITER_WFI_EN` defined: SLEEP state and `wfi_sleep` are implemented as above.
- `TRAP_ARBITER_WFI_EN` undefined:
  - `wfi` is ignored, so WFI behaves as a NOP;
  - the SLEEP state is absent;
  - `wfi_sleep` is tied to 0.

## Structure
- Shared package/defines header holds:
  - exception and interrupt cause codes;
  - `exc_vec` bit indices;
  - the FSM state encoding (2 bits);
  - the `mstatus` MIE bit index.
  - Existing `riscv_defines.vh` constants are reused where they already exist.
- Sub-module `trap_priority_encoder` (combinational). Takes `exc_vec`, `pend`, `privilege_mode`, `exc_tval`. Produces `sel_valid`, `sel_cause`, `sel_badaddr`.
- The FSM and output registers live in `trap_arbiter`.

## Test plan
- ILL only: `exc_valid=1`, `exc_vec=9'h004`, `exc_tval=32'h0000_0073` at cycle 10 → `exception_event` at cycle 11, `cause=2`, `badaddr=32'h73`; `busy` stays high until `redirect_done`.
- BRK and ILL together: `exc_vec=9'h00C` → `cause=3`, `badaddr=32'hFFFF_FFFF`.
- ECALL from U mode (`privilege_mode=0`) → `cause=8`. ECALL from M mode → `cause=11`, `badaddr=0`.
- Timer interrupt, M mode: `mip=mie=32'h80`, `mstatus[3]=1`, `insn_boundary=1`.
  - Expect `cause=32'h8000_0007`.
  - Repeat with `mstatus[3]=0` → no `exception_event`.
  - Repeat with `mstatus[3]=0` and `privilege_mode=0` → trap taken.
- Simultaneous LAF (`exc_vec=9'h040`) and pending MEI → `cause=5` first. After `redirect_done`, at the next boundary, `cause=32'h8000_000B`.
- WFI (`TRAP_ARBITER_WFI_EN`): assert `wfi` → `wfi_sleep=1` in the next cycle.
  - Raise `mip[7]` with `mie[7]=1` and `mstatus[3]=0` → IDLE next cycle, with no trap taken.
  - `resetn` asserted mid-WAIT → all outputs 0 immediately.
